// File: rtl/alu_pkg.sv
// alu_pkg
//  Shared definitions for the ALU issue controller: condition-code values,
//  controller FSM state encoding and bit positions inside the {N,Z,C,V} word.
package alu_pkg;

    // ARM-style condition codes carried on cmd_cond
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside an NZCV nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval
//  Purely combinational condition check: decides whether an operation with
//  condition code 'cond' executes given the current status flags.
//  Ports:
//   cond  in  4  condition code (COND_EQ..COND_NV)
//   nzcv  in  4  status flags {N,Z,C,V}
//   pass  out 1  1 when the condition holds
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // COND_NV
        endcase
    end

endmodule

// File: rtl/alu_issue_controller.sv
// alu_issue_controller
//  Issue/flag-holding side of a W-bit ALU. Takes one command per handshake,
//  registers operands and ALU_Control toward the external ALU, lets the ALU
//  settle for one cycle, then captures Result/NZCV into a response buffer.
//  Conditional execution is evaluated against the flags present at the
//  acceptance edge, so an op never sees its own flags.
//  Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_cond, cmd_setf  ALU_Control, condition code, flag-update enable
//   cmd_a, cmd_b                operands
//   alu_InA, alu_InB, alu_ctrl  registered drive toward the ALU
//   alu_Result, alu_NZCV        ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_nzcv, rsp_exec  response payload
//   flags                       live status register {N,Z,C,V}
//   exec_count                  executed-op counter, wraps silently
module alu_issue_controller
    import alu_pkg::*;
#(
    parameter int W     = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_cond,
    input  logic             cmd_setf,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    output logic [W-1:0]     alu_InA,
    output logic [W-1:0]     alu_InB,
    output logic [2:0]       alu_ctrl,
    input  logic [W-1:0]     alu_Result,
    input  logic [3:0]       alu_NZCV,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic [3:0]       rsp_nzcv,
    output logic             rsp_exec,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count
);

    state_t           state_reg;
    logic             cmd_ready_reg;
    logic [W-1:0]     ina_reg;
    logic [W-1:0]     inb_reg;
    logic [2:0]       ctrl_reg;
    logic             pass_reg;
    logic             setf_reg;
    logic             rsp_valid_reg;
    logic [W-1:0]     rsp_result_reg;
    logic [3:0]       rsp_nzcv_reg;
    logic             rsp_exec_reg;
    logic [3:0]       flags_reg;
    logic [CNT_W-1:0] exec_count_reg;
    logic             cond_pass;

    alu_cond_eval u_cond_eval (
        .cond (cmd_cond),
        .nzcv (flags_reg),
        .pass (cond_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cmd_ready_reg  <= 1'b0;
            ina_reg        <= '0;
            inb_reg        <= '0;
            ctrl_reg       <= '0;
            pass_reg       <= 1'b0;
            setf_reg       <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_nzcv_reg   <= '0;
            rsp_exec_reg   <= 1'b0;
            flags_reg      <= '0;
            exec_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // cmd_ready rises one cycle after reset release
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        ina_reg       <= cmd_a;
                        inb_reg       <= cmd_b;
                        ctrl_reg      <= cmd_op;
                        pass_reg      <= cond_pass;
                        setf_reg      <= cmd_setf;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU has had a full cycle to settle on the registered inputs
                    if (pass_reg) begin
                        rsp_result_reg <= alu_Result;
                        rsp_exec_reg   <= 1'b1;
                        exec_count_reg <= exec_count_reg + CNT_W'(1);
                        if (setf_reg) begin
                            flags_reg    <= alu_NZCV;
                            rsp_nzcv_reg <= alu_NZCV;
                        end else begin
                            rsp_nzcv_reg <= flags_reg;
                        end
                    end else begin
                        rsp_result_reg <= '0;
                        rsp_exec_reg   <= 1'b0;
                        rsp_nzcv_reg   <= flags_reg;
                    end
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_ready_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign alu_InA    = ina_reg;
    assign alu_InB    = inb_reg;
    assign alu_ctrl   = ctrl_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_nzcv   = rsp_nzcv_reg;
    assign rsp_exec   = rsp_exec_reg;
    assign flags      = flags_reg;
    assign exec_count = exec_count_reg;

endmodule

// File: tb/tb_alu_issue_controller.sv
// tb_alu_issue_controller
//  Directed bench with a stub ALU (Result/NZCV programmed per command).
//  The driver pushes hand-computed expected responses into a queue; a
//  monitor pops and compares whenever a response handshake occurs.
//  The counter is built 4 bits wide here so that wrap-around is reachable.
module tb_alu_issue_controller;

    localparam int W     = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_cond;
    logic             cmd_setf;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic [W-1:0]     alu_InA;
    logic [W-1:0]     alu_InB;
    logic [2:0]       alu_ctrl;
    logic [W-1:0]     alu_Result;
    logic [3:0]       alu_NZCV;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_result;
    logic [3:0]       rsp_nzcv;
    logic             rsp_exec;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_count;

    alu_issue_controller #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_cond   (cmd_cond),
        .cmd_setf   (cmd_setf),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_InA    (alu_InA),
        .alu_InB    (alu_InB),
        .alu_ctrl   (alu_ctrl),
        .alu_Result (alu_Result),
        .alu_NZCV   (alu_NZCV),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_nzcv   (rsp_nzcv),
        .rsp_exec   (rsp_exec),
        .flags      (flags),
        .exec_count (exec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     res;
        logic [3:0]       nzcv;
        logic             exec;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   txn    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a response is consumed at the posedge following a negedge
    // where both rsp_valid and rsp_ready are high.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                txn++;
                $display("rsp %0d: result=%b nzcv=%b exec=%0d count=%0d (exp %b %b %0d %0d)",
                         txn, rsp_result, rsp_nzcv, rsp_exec, exec_count,
                         e.res, e.nzcv, e.exec, e.cnt);
                check("rsp_result", 32'(rsp_result), 32'(e.res));
                check("rsp_nzcv",   32'(rsp_nzcv),   32'(e.nzcv));
                check("rsp_exec",   32'(rsp_exec),   32'(e.exec));
                check("exec_count", 32'(exec_count), 32'(e.cnt));
                check("flags",      32'(flags),      32'(e.nzcv));
            end
        end
    end

    // Present one command at a negedge, wait for acceptance, check issue
    // registers and latency; optionally wait for the response to drain.
    task automatic issue(input logic [3:0] cond, input logic setf, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] sres, input logic [3:0] snzcv,
                         input logic [W-1:0] eres, input logic [3:0] enzcv,
                         input logic eexec, input logic [CNT_W-1:0] ecnt,
                         input bit wait_done);
        exp_t e;
        int   n;
        cmd_cond   = cond;
        cmd_setf   = setf;
        cmd_op     = op;
        cmd_a      = a;
        cmd_b      = b;
        alu_Result = sres;
        alu_NZCV   = snzcv;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.res = eres; e.nzcv = enzcv; e.exec = eexec; e.cnt = ecnt;
        exp_q.push_back(e);
        @(negedge clk);                      // accepted at the edge in between
        cmd_valid = 1'b0;
        check("alu_InA", 32'(alu_InA), 32'(a));
        check("alu_InB", 32'(alu_InB), 32'(b));
        check("alu_ctrl", 32'(alu_ctrl), 32'(op));
        check("rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rsp_latency", 32'(rsp_valid), 32'd1);
        if (wait_done) begin
            n = 0;
            @(negedge clk);
            while (rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (rsp_valid) check("rsp_drain_timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cond = '0; cmd_setf = 1'b0;
        cmd_a = '0; cmd_b = '0; alu_Result = '0; alu_NZCV = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_count", 32'(exec_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        // Reset in the middle of EXEC: command dropped, no flag update
        cmd_cond = 4'hE; cmd_setf = 1'b1; cmd_op = 3'd3; cmd_a = 5'h1A; cmd_b = 5'h05;
        alu_Result = 5'h1F; alu_NZCV = 4'b1111; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_InA", 32'(alu_InA), 32'h1A);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_InA", 32'(alu_InA), 32'd0);
        check("midrst_InB", 32'(alu_InB), 32'd0);
        check("midrst_ctrl", 32'(alu_ctrl), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        check("midrst_flags2", 32'(flags), 32'd0);

        //    cond  setf op    a      b      stub res   nzcv     exp res    nzcv     ex cnt
        issue(4'hE, 1, 3'd0, 5'd3, 5'd3, 5'b00000, 4'b0100, 5'b00000, 4'b0100, 1, 4'd1, 1); // AL
        issue(4'h0, 0, 3'd1, 5'd1, 5'd6, 5'b00111, 4'b0000, 5'b00111, 4'b0100, 1, 4'd2, 1); // EQ
        issue(4'h1, 1, 3'd1, 5'd2, 5'd2, 5'b11111, 4'b1111, 5'b00000, 4'b0100, 0, 4'd2, 1); // NE
        issue(4'hE, 1, 3'd2, 5'd4, 5'd8, 5'b10000, 4'b1000, 5'b10000, 4'b1000, 1, 4'd3, 1); // AL
        issue(4'hB, 0, 3'd2, 5'd1, 5'd2, 5'b00011, 4'b0101, 5'b00011, 4'b1000, 1, 4'd4, 1); // LT
        issue(4'hA, 1, 3'd2, 5'd1, 5'd0, 5'b00001, 4'b0000, 5'b00000, 4'b1000, 0, 4'd4, 1); // GE
        issue(4'hE, 1, 3'd5, 5'd9, 5'd3, 5'b10101, 4'b1001, 5'b10101, 4'b1001, 1, 4'd5, 1); // AL
        issue(4'hA, 0, 3'd5, 5'd1, 5'd0, 5'b00001, 4'b0000, 5'b00001, 4'b1001, 1, 4'd6, 1); // GE
        issue(4'hD, 1, 3'd5, 5'd9, 5'd0, 5'b01001, 4'b0000, 5'b00000, 4'b1001, 0, 4'd6, 1); // LE
        issue(4'hC, 0, 3'd5, 5'd9, 5'd0, 5'b01001, 4'b0000, 5'b01001, 4'b1001, 1, 4'd7, 1); // GT
        issue(4'hE, 1, 3'd6, 5'd6, 5'd0, 5'b00110, 4'b0010, 5'b00110, 4'b0010, 1, 4'd8, 1); // AL
        issue(4'h8, 0, 3'd6, 5'd2, 5'd0, 5'b00010, 4'b0000, 5'b00010, 4'b0010, 1, 4'd9, 1); // HI
        issue(4'h9, 0, 3'd6, 5'd2, 5'd0, 5'b00010, 4'b0000, 5'b00000, 4'b0010, 0, 4'd9, 1); // LS
        issue(4'h4, 0, 3'd6, 5'd2, 5'd0, 5'b00010, 4'b0000, 5'b00000, 4'b0010, 0, 4'd9, 1); // MI
        issue(4'h7, 0, 3'd7, 5'd7, 5'd7, 5'b01110, 4'b0000, 5'b01110, 4'b0010, 1, 4'd10, 1); // VC

        // Backpressure: response held for 5 cycles with a new command pending
        rsp_ready = 1'b0;
        issue(4'hE, 0, 3'd4, 5'd10, 5'd0, 5'b01010, 4'b1111, 5'b01010, 4'b0010, 1, 4'd11, 0);
        cmd_cond = 4'h2; cmd_setf = 1'b1; cmd_op = 3'd4; cmd_a = 5'd11; cmd_b = 5'd1;
        alu_Result = 5'b01011; alu_NZCV = 4'b1100; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", 32'(rsp_result), 32'b01010);
            check("bp_nzcv", 32'(rsp_nzcv), 32'b0010);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        @(negedge clk);
        issue(4'h2, 1, 3'd4, 5'd11, 5'd1, 5'b01011, 4'b1100, 5'b01011, 4'b1100, 1, 4'd12, 1); // CS

        issue(4'hF, 1, 3'd0, 5'd1, 5'd1, 5'b11111, 4'b0001, 5'b00000, 4'b1100, 0, 4'd12, 1); // NV

        // Counter wrap 15 -> 0
        for (int i = 13; i <= 17; i++) begin
            issue(4'hE, 0, 3'd0, 5'(i), 5'd0, 5'(i), 4'b0000, 5'(i), 4'b1100, 1, CNT_W'(i), 1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
